// File: rtl/mem_rdata_router_pkg.sv
// Shared types for the SRAM read-return router: lane/select widths and the in-flight read tag.
// No logic, so no latency or backpressure; also supplies the default `D_width when none is given.
`ifndef D_width
`define D_width 32
`endif

package mem_rdata_pkg;
   localparam int NUM_PORT = 16;
   localparam int SEL_W    = 4;
   localparam int CNT_W    = 8;
   localparam logic [CNT_W-1:0] RD_CNT_MAX = 8'd255;

   typedef struct packed {
      logic             vld;
      logic [SEL_W-1:0] sel;
   } rd_tag_t;
endpackage

// File: rtl/mem_rdata_router_if.sv
// Bus bundle between request side, SRAM Q and the 16 consumer lanes; rd_cnt_out exists only
// with MEM_RDATA_CNT_EN. No latency of its own and no backpressure (no ready signals).
interface mem_rdata_router_if;
   import mem_rdata_pkg::*;

   logic [SEL_W-1:0]    sel_in;
   logic                r_enable;
   logic [`D_width-1:0] Q_in;
   logic [`D_width-1:0] rdata_out [NUM_PORT];
   logic [NUM_PORT-1:0] rvalid_out;
   logic                busy_out;
`ifdef MEM_RDATA_CNT_EN
   logic [CNT_W-1:0]    rd_cnt_out [NUM_PORT];
`endif

   modport master (
      output sel_in, r_enable, Q_in,
      input  rdata_out, rvalid_out, busy_out
`ifdef MEM_RDATA_CNT_EN
      , input rd_cnt_out
`endif
   );

   modport slave (
      input  sel_in, r_enable, Q_in,
      output rdata_out, rvalid_out, busy_out
`ifdef MEM_RDATA_CNT_EN
      , output rd_cnt_out
`endif
   );
endinterface

// File: rtl/mem_rdata_router_rd_tag_pipe.sv
// READ_LAT-deep delay line of read tags with synchronous clear; head is the tag issued READ_LAT
// edges ago. Shifts every cycle, never stalls, so it exerts no backpressure.
module rd_tag_pipe
   import mem_rdata_pkg::*;
#(
   parameter int READ_LAT = 1
) (
   input  logic    clk,
   input  logic    rst,
   input  rd_tag_t tag_in,
   output rd_tag_t head,
   output logic    any_vld
);

   rd_tag_t stage [READ_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < READ_LAT; i++) stage[i] <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < READ_LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign head = stage[READ_LAT-1];

   // Every stage is a register, so this OR is as registered as the pipeline itself.
   always_comb begin
      any_vld = 1'b0;
      for (int i = 0; i < READ_LAT; i++) any_vld = any_vld | stage[i].vld;
   end

endmodule

// File: rtl/mem_rdata_router.sv
// Steers SRAM Q to the issuing lane READ_LAT cycles after the read edge and pulses its rvalid;
// one read per cycle, no stall or backpressure. Per-lane saturating counters with MEM_RDATA_CNT_EN.
module mem_rdata_router
   import mem_rdata_pkg::*;
#(
   parameter int READ_LAT = 1
) (
   input logic               clk,
   input logic               rst,
   mem_rdata_router_if.slave bus
);

   rd_tag_t tag_in;
   rd_tag_t head;
   logic    any_vld;

   assign tag_in = '{vld: bus.r_enable, sel: bus.sel_in};

   rd_tag_pipe #(
      .READ_LAT (READ_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .head    (head),
      .any_vld (any_vld)
   );

   assign bus.busy_out = any_vld;

   // In-order pipeline guarantees at most one delivery per edge, hence one-hot rvalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rvalid_out <= '0;
         for (int i = 0; i < NUM_PORT; i++) bus.rdata_out[i] <= '0;
      end else begin
         bus.rvalid_out <= head.vld ? (NUM_PORT'(1) << head.sel) : '0;
         if (head.vld) bus.rdata_out[head.sel] <= bus.Q_in;
      end
   end

`ifdef MEM_RDATA_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PORT; i++) bus.rd_cnt_out[i] <= '0;
      end else if (head.vld && (bus.rd_cnt_out[head.sel] != RD_CNT_MAX)) begin
         bus.rd_cnt_out[head.sel] <= bus.rd_cnt_out[head.sel] + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_rdata_router.sv
// Drives four routers (READ_LAT 1..4) with one stimulus stream and checks them against an
// issue-log reference model; counter checks compile in with MEM_RDATA_CNT_EN.
module tb_mem_rdata_router;
   import mem_rdata_pkg::*;

   localparam int NI = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [SEL_W-1:0]    sel;
   logic                ren;
   logic [`D_width-1:0] qd;

   logic [NUM_PORT-1:0] obs_valid [NI];
   logic                obs_busy  [NI];
   logic [`D_width-1:0] obs_rdata [NI][NUM_PORT];
`ifdef MEM_RDATA_CNT_EN
   logic [CNT_W-1:0]    obs_cnt   [NI][NUM_PORT];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : gi
      mem_rdata_router_if u_if ();
      assign u_if.sel_in   = sel;
      assign u_if.r_enable = ren;
      assign u_if.Q_in     = qd;
      mem_rdata_router #(.READ_LAT(g + 1)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (u_if.slave)
      );
      assign obs_valid[g] = u_if.rvalid_out;
      assign obs_busy[g]  = u_if.busy_out;
      for (genvar l = 0; l < NUM_PORT; l++) begin : gl
         assign obs_rdata[g][l] = u_if.rdata_out[l];
`ifdef MEM_RDATA_CNT_EN
         assign obs_cnt[g][l] = u_if.rd_cnt_out[l];
`endif
      end
   end

   // Reference model: a log of which edges issued a live read, plus the last reset edge.
   bit                  iss_ren [0:2047];
   logic [SEL_W-1:0]    iss_sel [0:2047];
   int                  n_edge   = 0;
   int                  last_rst = 0;
   logic [NUM_PORT-1:0] exp_valid [NI];
   logic                exp_busy  [NI];
   logic [`D_width-1:0] exp_rdata [NI][NUM_PORT];
   int                  exp_cnt   [NI][NUM_PORT];

   int checks = 0;
   int passes = 0;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) passes++;
      else $error("FAIL %s: got %h want %h", tag, o, e);
   endtask

   task automatic step(input logic [3:0] s, input logic re, input logic [31:0] q, input logic r);
      sel = s; ren = re; qd = q; rst = r;
      @(posedge clk);
      n_edge++;
      iss_ren[n_edge] = re && !r;
      iss_sel[n_edge] = s;
      if (r) last_rst = n_edge;
      for (int g = 0; g < NI; g++) begin
         int lat = g + 1;
         int k   = n_edge - lat;
         exp_valid[g] = '0;
         exp_busy[g]  = 1'b0;
         if (r) begin
            for (int l = 0; l < NUM_PORT; l++) begin
               exp_rdata[g][l] = '0;
               exp_cnt[g][l]   = 0;
            end
         end else begin
            if (k >= 1 && k > last_rst && iss_ren[k]) begin
               exp_valid[g][iss_sel[k]] = 1'b1;
               exp_rdata[g][iss_sel[k]] = q;
               if (exp_cnt[g][iss_sel[k]] < 255) exp_cnt[g][iss_sel[k]]++;
            end
            for (int j = n_edge - lat + 1; j <= n_edge; j++)
               if (j >= 1 && j > last_rst && iss_ren[j]) exp_busy[g] = 1'b1;
         end
      end
      #1;
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("L%0d rvalid e%0d", g + 1, n_edge), 32'(obs_valid[g]), 32'(exp_valid[g]));
         chk($sformatf("L%0d busy e%0d", g + 1, n_edge), 32'(obs_busy[g]), 32'(exp_busy[g]));
         for (int l = 0; l < NUM_PORT; l++) begin
            chk($sformatf("L%0d rdata[%0d] e%0d", g + 1, l, n_edge), obs_rdata[g][l], exp_rdata[g][l]);
`ifdef MEM_RDATA_CNT_EN
            chk($sformatf("L%0d cnt[%0d] e%0d", g + 1, l, n_edge), 32'(obs_cnt[g][l]), 32'(exp_cnt[g][l]));
`endif
         end
      end
   endtask

   initial begin
      sel = '0; ren = 1'b0; qd = '0; rst = 1'b1;

      // Reset values
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      for (int g = 0; g < NI; g++) begin
         chk("reset rvalid", 32'(obs_valid[g]), 32'h0);
         chk("reset busy", 32'(obs_busy[g]), 32'h0);
         chk("reset rdata0", obs_rdata[g][0], 32'h0);
      end

      // Single read to lane 5, Q returned one cycle later
      step(5, 1, 32'h0, 0);
      chk("L1 busy after issue", 32'(obs_busy[0]), 32'h1);
      step(0, 0, 32'hA5A5_0001, 0);
      chk("L1 single rvalid", 32'(obs_valid[0]), 32'h0020);
      chk("L1 single rdata5", obs_rdata[0][5], 32'hA5A5_0001);
      step(0, 0, 32'h1234_5678, 0);
      chk("L1 single rvalid drop", 32'(obs_valid[0]), 32'h0);
      chk("L1 single rdata5 held", obs_rdata[0][5], 32'hA5A5_0001);
      for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0);

      // Burst 0,15,3,3 with Q 1..4 arriving two cycles behind each issue
      step(0, 1, 32'h0, 0);
      step(15, 1, 32'h0, 0);
      step(3, 1, 32'h1, 0);
      chk("L2 burst p0", 32'(obs_valid[1]), 32'h0001);
      step(3, 1, 32'h2, 0);
      chk("L2 burst p1", 32'(obs_valid[1]), 32'h8000);
      step(0, 0, 32'h3, 0);
      chk("L2 burst p2", 32'(obs_valid[1]), 32'h0008);
      step(0, 0, 32'h4, 0);
      chk("L2 burst p3", 32'(obs_valid[1]), 32'h0008);
      chk("L2 burst rdata3", obs_rdata[1][3], 32'h4);
      chk("L2 burst rdata15", obs_rdata[1][15], 32'h2);
      for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0);

      // Writes are ignored
      for (int i = 0; i < 4; i++) begin
         step(7, 0, 32'hDEAD_BEEF, 0);
         for (int g = 0; g < NI; g++) begin
            chk("write no rvalid", 32'(obs_valid[g]), 32'h0);
            chk("write busy", 32'(obs_busy[g]), 32'h0);
            chk("write rdata7", obs_rdata[g][7], 32'h0);
         end
      end

      // Reset while reads to lanes 1 and 2 are in flight
      step(1, 1, 32'h11, 0);
      step(2, 1, 32'h22, 0);
      step(0, 0, 32'h33, 1);
      chk("L3 busy after rst", 32'(obs_busy[2]), 32'h0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 32'h4400 + 32'(i), 0);
         chk("L3 no stale rvalid", 32'(obs_valid[2]), 32'h0);
      end

      // Randomized traffic, occasional resets
      for (int i = 0; i < 400; i++)
         step(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), $urandom,
              ($urandom_range(0, 59) == 0));
      for (int i = 0; i < 5; i++) step(0, 0, $urandom, 0);

`ifdef MEM_RDATA_CNT_EN
      // Counter saturation on lane 9
      step(0, 0, 32'h0, 1);
      for (int i = 0; i < 300; i++) step(9, 1, $urandom, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0);
      for (int g = 0; g < NI; g++) begin
         chk("cnt9 saturated", 32'(obs_cnt[g][9]), 32'd255);
         chk("cnt0 untouched", 32'(obs_cnt[g][0]), 32'd0);
      end
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passes, checks);
      $fatal(1);
   end

endmodule

// File: doc/mem_rdata_router.md
Name: mem_rdata_router

Overview:
- Read-return path for a 16-requester shared SRAM port.
- The request mux drives CEN/A/D/WEN from one of 16 lanes per cycle. This block tracks each read issued (sel_in, r_enable) through the SRAM read latency.
- When the read completes, it steers SRAM Q to the issuing lane's holding register and pulses that lane's valid.
- Sits beside the request mux, between the SRAM macro and the 16 consumer lanes.

Parameters:
- READ_LAT, 1: SRAM cycles from request edge to Q sampled; legal range 1..4.
- NUM_PORT, 16: number of lanes; fixed at 16, matching the 4-bit select.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- sel_in  in  4  lane issuing this cycle; same signal that feeds the request mux
- r_enable  in  1  1 = read issued this cycle (the SRAM sees CEN=0, WEN=1); 0 = write or idle, nothing to track
- Q_in  in  `D_width  SRAM read data
- rdata_out  out  NUM_PORT x `D_width  per-lane held read data (unpacked array)
- rvalid_out  out  NUM_PORT  per-lane one-cycle pulse: new data in rdata_out[i]
- busy_out  out  1  1 while any read is in flight
- rd_cnt_out  out  NUM_PORT x 8  per-lane returned-read count; present only with MEM_RDATA_CNT_EN

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - tag pipeline cleared; all in-flight reads dropped, never delivered
  - rdata_out[*]=0, rvalid_out=0, busy_out=0, rd_cnt_out[*]=0
- Tag capture:
  - at edge E0 with r_enable=1, push tag {vld=1, sel=sel_in} into a READ_LAT-deep shift register
  - r_enable=0 pushes {vld=0}
  - shifts every cycle; no stall
- Delivery:
  - at edge E_READ_LAT, if the head tag has vld=1: rdata_out[sel] <= Q_in and rvalid_out[sel] <= 1
  - all other rvalid bits <= 0
  - rvalid_out is visible for exactly the cycle after edge E_READ_LAT
  - latency from request edge to rvalid high is READ_LAT cycles
- Holding: rdata_out[i] holds its last delivered value until that lane's next delivery. Writes never modify rdata_out.
- Throughput: one read per cycle sustained, any lane mix.
- Back-to-back reads to the same lane produce consecutive pulses; rdata_out updates each cycle.
- At most one rvalid_out bit is high per cycle (one-hot or zero).
- Reads never overlap at delivery, because the pipeline is strictly in order.
- busy_out = OR of vld over all pipeline stages, registered alongside the pipeline. It is 1 from the cycle after the first read issue until the cycle after the last delivery.
- Simultaneous issue and delivery on the same lane: delivery uses the older tag; the new tag enters the pipeline normally.
- rst asserted mid-burst: next cycle all outputs are at reset values. Q_in returning afterwards for pre-reset requests is ignored.
- sel_in is fully decoded (all 16 codes valid); no default or error path is needed.

Optional Feature:
- Macro: MEM_RDATA_CNT_EN.
- Defined:
  - each lane has an 8-bit counter, incremented on every delivery to that lane
  - saturates at 255 (no wrap)
  - cleared only by rst
  - exposed on rd_cnt_out
- Undefined: counters and the rd_cnt_out port are absent; all other behaviour is identical.

Decomposition:
- Package mem_rdata_pkg:
  - NUM_PORT=16, SEL_W=4, CNT_W=8, RD_CNT_MAX=8'd255
  - typedef struct packed {logic vld; logic [SEL_W-1:0] sel;} rd_tag_t
- Sub-module rd_tag_pipe: READ_LAT-parameterised delay line of rd_tag_t with synchronous clear. It provides the head tag and any_vld (which feeds busy_out).
- The top level holds the lane registers, the valid decode and the optional counters.

Test Plan:
- Reset values: after rst, every rdata_out=0, rvalid_out=16'h0000, busy_out=0.
- Single read, READ_LAT=1: read lane 5 at edge 0, Q_in=32'hA5A5_0001 one cycle later -> rvalid_out=16'h0020 for exactly one cycle; rdata_out[5]=32'hA5A5_0001 held afterwards.
- Burst: reads to lanes 0,15,3,3 on consecutive cycles with Q_in=1,2,3,4, READ_LAT=2 -> pulses on lanes 0,15,3,3 on consecutive cycles starting 2 cycles after the first issue. Final rdata_out[3]=4, rdata_out[15]=2.
- Writes ignored: r_enable=0 with sel_in=7 and Q_in=32'hDEAD_BEEF -> no rvalid, rdata_out[7] unchanged, busy_out=0.
- Reset mid-flight, READ_LAT=3: issue reads to lanes 1 and 2, assert rst one cycle later -> no rvalid ever fires for lanes 1 or 2; busy_out=0 the cycle after rst.
- Counter saturation (MEM_RDATA_CNT_EN): 300 reads to lane 9 -> rd_cnt_out[9]=255, other lanes 0; macro undefined -> port absent and remaining tests pass unchanged.
